// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bundle: RAM read-port arbitration, redirect inputs and the registered ID hand-off.
// The master modport belongs to the fetch stage; the slave modport belongs to the surrounding pipeline/RAM.
interface instr_fetch_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_rd_req;
    logic              ram_addr_sel;
    logic [ADDR_W-1:0] if_read_addr;
    logic [DATA_W-1:0] if_read_data;
    logic              id_stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;
    logic [15:0]       bubble_cnt;

    modport master (
        input  mem_rd_req, if_read_data, id_stall, br_taken, br_target,
        output ram_addr_sel, if_read_addr, if_instr, if_pc, if_valid, bubble_cnt
    );

    modport slave (
        output mem_rd_req, if_read_data, id_stall, br_taken, br_target,
        input  ram_addr_sel, if_read_addr, if_instr, if_pc, if_valid, bubble_cnt
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, shares the RAM read port with MEM, registers instructions to ID.
// Latency 1 cycle from issue edge to if_valid; id_stall holds the output and parks one return in a skid entry.
module instr_fetch_stage #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
    input  logic                 gclk,
    input  logic                 rst,
    instr_fetch_stage_if.master  bus
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend;
    logic              skid_v;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic [15:0]       bubble_q;

    logic              issue;
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       bubble_nxt;

    // A fetch may only go out when its return is guaranteed a home next cycle.
    always_comb begin
        issue      = !bus.mem_rd_req && !skid_v && !(bus.id_stall && pend) && !bus.br_taken;
        pc_inc     = pc + ADDR_W'(1);
        bubble_nxt = (bubble_q == 16'hFFFF) ? bubble_q : bubble_q + 16'd1;
    end

    assign bus.ram_addr_sel = bus.mem_rd_req;
    assign bus.if_read_addr = pc;
    assign bus.if_instr     = instr_q;
    assign bus.if_pc        = pc_q;
    assign bus.if_valid     = valid_q;
    assign bus.bubble_cnt   = bubble_q;

    always_ff @(posedge gclk) begin
        if (rst) begin
            pc         <= RESET_PC;
            pend       <= 1'b0;
            pend_pc    <= '0;
            skid_v     <= 1'b0;
            skid_instr <= NOP_WORD;
            skid_pc    <= '0;
            instr_q    <= NOP_WORD;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            bubble_q   <= 16'd0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_pc <= pc;
                pc      <= pc_inc;
            end

            // Redirect squashes the in-flight fetch and any parked return, even under stall.
            if (bus.br_taken) begin
                pc       <= bus.br_target;
                skid_v   <= 1'b0;
                instr_q  <= NOP_WORD;
                valid_q  <= 1'b0;
                bubble_q <= bubble_nxt;
            end else if (bus.id_stall) begin
                if (pend) begin
                    skid_v     <= 1'b1;
                    skid_instr <= bus.if_read_data;
                    skid_pc    <= pend_pc;
                end
            end else if (skid_v) begin
                instr_q <= skid_instr;
                pc_q    <= skid_pc;
                valid_q <= 1'b1;
                skid_v  <= 1'b0;
            end else if (pend) begin
                instr_q <= bus.if_read_data;
                pc_q    <= pend_pc;
                valid_q <= 1'b1;
            end else begin
                instr_q  <= NOP_WORD;
                valid_q  <= 1'b0;
                bubble_q <= bubble_nxt;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench: the expected program stream (sequential from reset or redirect target) is queued
// by the driver; a negedge monitor pops it on each delivered instruction and checks holds/bubbles/counter.
module tb_instr_fetch_stage;
    localparam logic [15:0] NOP = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;

    logic gclk = 1'b0;
    logic rst;
    logic [15:0] rdata;

    int   checks = 0;
    int   errors = 0;
    int   deliveries = 0;
    exp_t exp_q[$];
    logic [15:0] stream_pc;

    instr_fetch_stage_if bus ();

    instr_fetch_stage dut (
        .gclk (gclk),
        .rst  (rst),
        .bus  (bus.master)
    );

    always #5 gclk = ~gclk;

    function automatic logic [15:0] ram_fn(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h1000;
    endfunction

    // Single read port: MEM data comes back when MEM owned the port.
    always @(posedge gclk)
        rdata <= bus.ram_addr_sel ? (16'hBAD0 ^ bus.if_read_addr) : ram_fn(bus.if_read_addr);
    assign bus.if_read_data = rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: stream_pc, ins: ram_fn(stream_pc)});
            stream_pc = stream_pc + 16'd1;
        end
    endtask

    task automatic redirect(input logic [15:0] tgt);
        exp_q.delete();
        stream_pc = tgt;
        topup();
    endtask

    task automatic step();
        @(negedge gclk);
        #1;
        topup();
    endtask

    // Monitor: inputs seen at negedge are the ones the preceding posedge acted on.
    initial begin
        logic [15:0] prev_instr, prev_pc;
        logic        prev_valid;
        int          exp_bubble;
        exp_t        e;
        prev_instr = NOP; prev_pc = '0; prev_valid = 1'b0; exp_bubble = 0;
        forever begin
            @(negedge gclk);
            chk("ram_addr_sel", 32'(bus.ram_addr_sel), 32'(bus.mem_rd_req));
            chk("skid_pend_excl", 32'(dut.pend & dut.skid_v), 32'd0);
            if (rst) begin
                exp_bubble = 0;
                chk("rst_valid", 32'(bus.if_valid), 32'd0);
                chk("rst_instr", 32'(bus.if_instr), 32'(NOP));
                chk("rst_pc", 32'(bus.if_pc), 32'd0);
            end else if (bus.br_taken) begin
                chk("br_valid", 32'(bus.if_valid), 32'd0);
                chk("br_instr", 32'(bus.if_instr), 32'(NOP));
                if (exp_bubble < 65535) exp_bubble++;
            end else if (bus.id_stall) begin
                chk("hold_instr", 32'(bus.if_instr), 32'(prev_instr));
                chk("hold_pc", 32'(bus.if_pc), 32'(prev_pc));
                chk("hold_valid", 32'(bus.if_valid), 32'(prev_valid));
            end else if (bus.if_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL deliver: got pc %h with no expected entry", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", 32'(bus.if_pc), 32'(e.pc));
                    chk("deliver_instr", 32'(bus.if_instr), 32'(e.ins));
                    deliveries++;
                end
            end else begin
                chk("bubble_instr", 32'(bus.if_instr), 32'(NOP));
                if (exp_bubble < 65535) exp_bubble++;
            end
            chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(exp_bubble));
            prev_instr = bus.if_instr;
            prev_pc    = bus.if_pc;
            prev_valid = bus.if_valid;
        end
    end

    initial begin
        int d0;
        logic [15:0] tgt;
        rst = 1'b1;
        bus.mem_rd_req = 1'b0;
        bus.id_stall   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        redirect(16'h0000);
        step(); step();

        // Free run after reset release
        rst = 1'b0;
        step(); step();
        chk("first_valid", 32'(bus.if_valid), 32'd1);
        chk("first_pc", 32'(bus.if_pc), 32'd0);
        chk("first_bubbles", 32'(bus.bubble_cnt), 32'd1);
        step(); step(); step();
        chk("pc_at_5", 32'(bus.if_read_addr), 32'd5);

        // MEM owns the port for 3 cycles
        bus.mem_rd_req = 1'b1;
        step(); step(); step();
        chk("pc_hold_mem", 32'(bus.if_read_addr), 32'd5);
        bus.mem_rd_req = 1'b0;
        step();
        chk("mem_bubbles", 32'(bus.bubble_cnt), 32'd4);
        step();
        chk("resume_pc", 32'(bus.if_pc), 32'd5);
        step();

        // Decode stall with a fetch in flight
        bus.id_stall = 1'b1;
        step(); step();
        chk("stall_hold", 32'(bus.if_pc), 32'd6);
        bus.id_stall = 1'b0;
        step(); step(); step();

        // Redirect while stalled with a fetch pending
        bus.id_stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 16'h0040;
        redirect(16'h0040);
        step();
        chk("br_addr", 32'(bus.if_read_addr), 32'h0040);
        chk("br_skid", 32'(dut.skid_v), 32'd0);
        bus.id_stall = 1'b0; bus.br_taken = 1'b0;
        step(); step();
        chk("br_first_pc", 32'(bus.if_pc), 32'h0040);
        chk("br_first_valid", 32'(bus.if_valid), 32'd1);

        // PC wrap
        bus.br_taken = 1'b1; bus.br_target = 16'hFFFE;
        redirect(16'hFFFE);
        step();
        chk("wrap_a0", 32'(bus.if_read_addr), 32'hFFFE);
        bus.br_taken = 1'b0;
        step();
        chk("wrap_a1", 32'(bus.if_read_addr), 32'hFFFF);
        step();
        chk("wrap_a2", 32'(bus.if_read_addr), 32'h0000);
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic with a mid-run reset
        d0 = deliveries;
        for (int i = 0; i < 3000; i++) begin
            bus.mem_rd_req = ($urandom_range(0, 3) == 0);
            bus.id_stall   = ($urandom_range(0, 3) == 0);
            bus.br_taken   = 1'b0;
            rst            = 1'b0;
            if (i == 1500) begin
                rst = 1'b1;
                redirect(16'h0000);
            end else if ($urandom_range(0, 31) == 0) begin
                tgt = 16'($urandom);
                if ($urandom_range(0, 3) == 0) tgt[15:2] = '1;
                bus.br_taken  = 1'b1;
                bus.br_target = tgt;
                redirect(tgt);
            end
            step();
        end
        rst = 1'b0; bus.mem_rd_req = 1'b0; bus.id_stall = 1'b0; bus.br_taken = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("progress", 32'(deliveries - d0 > 1000), 32'd1);

        // Bubble counter saturation
        bus.mem_rd_req = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        chk("sat_cnt", 32'(bus.bubble_cnt), 32'hFFFF);
        bus.mem_rd_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("sat_hold", 32'(bus.bubble_cnt), 32'hFFFF);
        chk("sat_valid", 32'(bus.if_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
